// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background ECC scrubber for the data cache SRAM.
// Walks every set in turn. It reads one set, inspects the per-way error
// flags from the corrector, and writes back only the ways holding a
// single-bit (correctable) error. The arbiter lock is held between the
// read and the write-back so that no functional write can slip in
// between them. The block also keeps saturating error statistics.
module ecc_scrub_ctrl #(
  parameter int NUM_SETS     = 256,
  parameter int ASSOC        = 8,
  parameter int SCRUB_PERIOD = 1024,
  parameter int CNT_WIDTH    = 16,
  localparam int AW          = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic                 lock_o,
  output logic                 we_o,
  output logic [AW-1:0]        addr_o,
  output logic [ASSOC-1:0]     be_o,
  input  logic [2*ASSOC-1:0]   err_i,
  output logic [CNT_WIDTH-1:0] corr_cnt_o,
  output logic [CNT_WIDTH-1:0] uncorr_cnt_o,
  output logic                 uncorr_irq_o,
  output logic                 sweep_done_o,
  output logic                 busy_o
);

  // The timer only ever holds 0..SCRUB_PERIOD-1.
  localparam int TW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  // This is wide enough to hold a popcount of 0..ASSOC.
  localparam int PW = $clog2(ASSOC + 1);
  localparam int SW = CNT_WIDTH + 1;

  localparam logic [TW-1:0] TIMER_RELOAD = TW'(SCRUB_PERIOD - 1);
  localparam logic [AW-1:0] LAST_SET     = AW'(NUM_SETS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_CHECK,
    ST_WRITE,
    ST_NEXT
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [AW-1:0]        index;
  logic [TW-1:0]        timer;
  logic [ASSOC-1:0]     wb_mask;
  logic [CNT_WIDTH-1:0] corr_cnt;
  logic [CNT_WIDTH-1:0] uncorr_cnt;

  logic [ASSOC-1:0]     corr_mask;
  logic [ASSOC-1:0]     uncorr_mask;
  logic [PW-1:0]        corr_pop;
  logic [PW-1:0]        uncorr_pop;

  // Add a small popcount to a counter, and clamp the result at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PW-1:0]        b);
    logic [SW-1:0] sum;
    sum = {1'b0, a} + SW'(b);
    if (sum[CNT_WIDTH]) begin
      return '1;
    end
    return sum[CNT_WIDTH-1:0];
  endfunction

  // Split the per-way 2-bit error codes into corrected and uncorrectable masks.
  // A code of 2'b01 is corrected. Any code with the high bit set is uncorrectable.
  always_comb begin
    corr_mask   = '0;
    uncorr_mask = '0;
    for (int w = 0; w < ASSOC; w++) begin
      corr_mask[w]   = (err_i[2*w +: 2] == 2'b01);
      uncorr_mask[w] = err_i[2*w + 1];
    end
  end

  // Count the flagged ways in each mask for the statistics counters.
  always_comb begin
    corr_pop   = '0;
    uncorr_pop = '0;
    for (int w = 0; w < ASSOC; w++) begin
      corr_pop   = corr_pop + PW'(corr_mask[w]);
      uncorr_pop = uncorr_pop + PW'(uncorr_mask[w]);
    end
  end

  // State register. Reset drops straight back to IDLE, which also releases the lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Once a read has been issued, the set is always finished, even if enable drops.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable_i) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable_i) begin
          state_next = ST_IDLE;
        end else if (timer == '0) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (gnt_i) begin
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (|corr_mask) begin
          state_next = ST_WRITE;
        end else begin
          state_next = ST_NEXT;
        end
      end
      ST_WRITE: begin
        if (gnt_i) begin
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (enable_i) begin
          state_next = ST_WAIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Idle-gap timer. It is reloaded on each entry to WAIT and counts down to zero while in WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer <= '0;
    end else if (state_next == ST_WAIT && state != ST_WAIT) begin
      timer <= TIMER_RELOAD;
    end else if (state == ST_WAIT && timer != '0) begin
      timer <= timer - 1'b1;
    end
  end

  // Set index. It advances once per completed set, wraps at the last set, and is kept while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      index <= '0;
    end else if (state == ST_NEXT) begin
      index <= (index == LAST_SET) ? '0 : index + 1'b1;
    end
  end

  // Capture the corrected-way mask in CHECK. It stays stable through the whole write-back request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_mask <= '0;
    end else if (state == ST_CHECK) begin
      wb_mask <= corr_mask;
    end
  end

  // Update the error statistics once per scrubbed set, from the sample taken in CHECK.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (state == ST_CHECK) begin
      corr_cnt   <= sat_add(corr_cnt, corr_pop);
      uncorr_cnt <= sat_add(uncorr_cnt, uncorr_pop);
    end
  end

  // Decode outputs from the state. The request fields depend only on registers, so they hold steady until the grant.
  always_comb begin
    req_o        = 1'b0;
    we_o         = 1'b0;
    lock_o       = 1'b0;
    be_o         = '0;
    uncorr_irq_o = 1'b0;
    sweep_done_o = 1'b0;
    busy_o       = 1'b1;
    addr_o       = index;
    case (state)
      ST_IDLE, ST_WAIT: begin
        busy_o = 1'b0;
      end
      ST_READ: begin
        req_o = 1'b1;
      end
      ST_CHECK: begin
        lock_o       = 1'b1;
        uncorr_irq_o = |uncorr_mask;
      end
      ST_WRITE: begin
        req_o  = 1'b1;
        we_o   = 1'b1;
        lock_o = 1'b1;
        be_o   = wb_mask;
      end
      ST_NEXT: begin
        sweep_done_o = (index == LAST_SET);
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign corr_cnt_o   = corr_cnt;
  assign uncorr_cnt_o = uncorr_cnt;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl: randomized self-checking bench for ecc_scrub_ctrl.
// A transaction-level model tracks the expected set index and the error
// totals. For each scrubbed set it derives the expected request fields,
// the write-back mask, the interrupt and the sweep pulse.
module tb_ecc_scrub_ctrl;

  localparam int NUM_SETS     = 16;
  localparam int ASSOC        = 8;
  localparam int SCRUB_PERIOD = 4;
  localparam int CNT_WIDTH    = 10;
  localparam int AW           = $clog2(NUM_SETS);
  localparam int CNT_MAX      = (1 << CNT_WIDTH) - 1;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 enable_i = 1'b0;
  logic                 gnt_i = 1'b0;
  logic [2*ASSOC-1:0]   err_i = '0;
  logic                 req_o;
  logic                 lock_o;
  logic                 we_o;
  logic [AW-1:0]        addr_o;
  logic [ASSOC-1:0]     be_o;
  logic [CNT_WIDTH-1:0] corr_cnt_o;
  logic [CNT_WIDTH-1:0] uncorr_cnt_o;
  logic                 uncorr_irq_o;
  logic                 sweep_done_o;
  logic                 busy_o;

  int  checks = 0;
  int  errors = 0;
  int  exp_idx = 0;
  int  exp_corr = 0;
  int  exp_uncorr = 0;
  bit  aborted = 1'b0;

  ecc_scrub_ctrl #(
    .NUM_SETS    (NUM_SETS),
    .ASSOC       (ASSOC),
    .SCRUB_PERIOD(SCRUB_PERIOD),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .lock_o      (lock_o),
    .we_o        (we_o),
    .addr_o      (addr_o),
    .be_o        (be_o),
    .err_i       (err_i),
    .corr_cnt_o  (corr_cnt_o),
    .uncorr_cnt_o(uncorr_cnt_o),
    .uncorr_irq_o(uncorr_irq_o),
    .sweep_done_o(sweep_done_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (set %0d)", tag, actual, expected, exp_idx);
    end
  endtask

  function automatic logic [63:0] mkBus(input logic req, input logic we, input logic lock,
                                        input logic busy, input int addr,
                                        input logic [ASSOC-1:0] be);
    logic [AW-1:0] a;
    a = AW'(addr);
    return 64'({req, we, lock, busy, a, be});
  endfunction

  function automatic logic [63:0] dutBus();
    return 64'({req_o, we_o, lock_o, busy_o, addr_o, be_o});
  endfunction

  function automatic logic [ASSOC-1:0] corrOf(input logic [2*ASSOC-1:0] e);
    logic [ASSOC-1:0] m;
    m = '0;
    for (int w = 0; w < ASSOC; w++) m[w] = (e[2*w+1] == 1'b0) && (e[2*w] == 1'b1);
    return m;
  endfunction

  function automatic logic [ASSOC-1:0] uncorrOf(input logic [2*ASSOC-1:0] e);
    logic [ASSOC-1:0] m;
    m = '0;
    for (int w = 0; w < ASSOC; w++) m[w] = e[2*w+1];
    return m;
  endfunction

  function automatic int satAdd(input int a, input int n);
    return (a + n > CNT_MAX) ? CNT_MAX : a + n;
  endfunction

  function automatic logic [2*ASSOC-1:0] randErr();
    logic [2*ASSOC-1:0] e;
    int r;
    e = '0;
    for (int w = 0; w < ASSOC; w++) begin
      r = int'($urandom_range(0, 9));
      if (r == 6 || r == 7) e[2*w +: 2] = 2'b01;
      else if (r == 8)      e[2*w +: 2] = 2'b10;
      else if (r == 9)      e[2*w +: 2] = 2'b11;
    end
    return e;
  endfunction

  function automatic logic [2*ASSOC-1:0] corrWays(input int n);
    logic [2*ASSOC-1:0] e;
    e = '0;
    for (int w = 0; w < ASSOC; w++) if (w < n) e[2*w +: 2] = 2'b01;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scrub one set. Optionally delay the grants, drop enable, or hit reset in the first write cycle.
  task automatic applyStimulus(input logic [2*ASSOC-1:0] pattern, input int rd_wait,
                               input int wr_wait, input bit drop_enable, input bit rst_in_write);
    logic [ASSOC-1:0] cm;
    logic [ASSOC-1:0] um;
    int waited;
    bit wrap;
    if (aborted) return;
    cm = corrOf(pattern);
    um = uncorrOf(pattern);
    waited = 0;
    tick(); gnt_i = 1'b0; err_i = '0; #1;
    while (!req_o && waited < SCRUB_PERIOD + 20) begin
      waited++;
      tick(); gnt_i = 1'b0; err_i = '0; #1;
    end
    if (!req_o) begin
      checkOutput("req_timeout", 64'(req_o), 64'd1);
      aborted = 1'b1;
      return;
    end
    checkOutput("idle_gap", 64'(waited), 64'(SCRUB_PERIOD));
    for (int k = 0; k <= rd_wait; k++) begin
      if (k > 0) tick();
      gnt_i = (k == rd_wait);
      #1;
      checkOutput("rd_bus", dutBus(), mkBus(1'b1, 1'b0, 1'b0, 1'b1, exp_idx, '0));
    end
    tick(); gnt_i = 1'($urandom_range(0, 1)); err_i = pattern;
    if (drop_enable && cm == '0) enable_i = 1'b0;
    #1;
    checkOutput("chk_bus", dutBus(), mkBus(1'b0, 1'b0, 1'b1, 1'b1, exp_idx, '0));
    checkOutput("irq", 64'(uncorr_irq_o), 64'(|um));
    exp_corr   = satAdd(exp_corr, $countones(cm));
    exp_uncorr = satAdd(exp_uncorr, $countones(um));
    if (cm != '0) begin
      for (int k = 0; k <= wr_wait; k++) begin
        tick(); err_i = '0; gnt_i = (k == wr_wait);
        if (k == 0 && drop_enable) enable_i = 1'b0;
        if (k == 0 && rst_in_write) begin
          rst_ni = 1'b0;
          #1;
          checkOutput("rst_lock", 64'(lock_o), 64'd0);
          checkOutput("rst_wr_bus", dutBus(), 64'd0);
          checkOutput("rst_wr_cnt", 64'({corr_cnt_o, uncorr_cnt_o}), 64'd0);
          exp_idx = 0; exp_corr = 0; exp_uncorr = 0;
          gnt_i = 1'b0;
          return;
        end
        #1;
        checkOutput("wr_bus", dutBus(), mkBus(1'b1, 1'b1, 1'b1, 1'b1, exp_idx, cm));
      end
    end
    tick(); gnt_i = 1'($urandom_range(0, 1)); err_i = '0; #1;
    wrap = (exp_idx == NUM_SETS - 1);
    checkOutput("next_bus", dutBus(), mkBus(1'b0, 1'b0, 1'b0, 1'b1, exp_idx, '0));
    checkOutput("sweep_done", 64'(sweep_done_o), 64'(wrap));
    checkOutput("corr_cnt", 64'(corr_cnt_o), 64'(exp_corr));
    checkOutput("uncorr_cnt", 64'(uncorr_cnt_o), 64'(exp_uncorr));
    exp_idx = wrap ? 0 : exp_idx + 1;
  endtask

  // Confirm that the scrubber sits in IDLE, with the index retained and any stray grants ignored.
  task automatic checkIdle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick(); gnt_i = 1'($urandom_range(0, 1)); #1;
      checkOutput("idle_bus", dutBus(), mkBus(1'b0, 1'b0, 1'b0, 1'b0, exp_idx, '0));
    end
    gnt_i = 1'b0;
  endtask

  initial begin
    int n;
    tick(); tick();
    checkOutput("rst_bus", dutBus(), 64'd0);
    checkOutput("rst_cnt", 64'({corr_cnt_o, uncorr_cnt_o}), 64'd0);
    checkOutput("rst_pulses", 64'({uncorr_irq_o, sweep_done_o}), 64'd0);
    rst_ni = 1'b1;
    enable_i = 1'b1;

    // Run a clean sweep across every set, then carry on to cover the directed sets 3 and 5.
    for (int i = 0; i < NUM_SETS + 6; i++) begin
      if (i == NUM_SETS + 3)      applyStimulus(16'h0009, 0, 0, 1'b0, 1'b0);
      else if (i == NUM_SETS + 5) applyStimulus(16'h1010, 10, 10, 1'b0, 1'b0);
      else                        applyStimulus('0, 0, 0, 1'b0, 1'b0);
    end

    // Scrub sets with random error patterns and random grant latencies.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(randErr(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    // Push the corrected-way counter up to its limit, then check that it saturates.
    while (!aborted && exp_corr < CNT_MAX - 1) begin
      n = CNT_MAX - 1 - exp_corr;
      if (n > ASSOC) n = ASSOC;
      applyStimulus(corrWays(n), 0, 0, 1'b0, 1'b0);
    end
    applyStimulus(corrWays(3), 0, 0, 1'b0, 1'b0);
    checkOutput("corr_sat", 64'(corr_cnt_o), 64'(CNT_MAX));

    // Drop enable in the middle of a write-back. The set must still finish, and the FSM then idles.
    applyStimulus(16'h0001, 1, 2, 1'b1, 1'b0);
    checkIdle(5);
    enable_i = 1'b1;
    applyStimulus('0, 0, 0, 1'b0, 1'b0);

    // Assert reset during WAIT. Everything must clear, and scrubbing resumes from set 0.
    tick(); tick();
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_wait_bus", dutBus(), 64'd0);
    checkOutput("rst_wait_cnt", 64'({corr_cnt_o, uncorr_cnt_o}), 64'd0);
    exp_idx = 0; exp_corr = 0; exp_uncorr = 0;
    tick(); rst_ni = 1'b1;
    applyStimulus(16'h0004, 0, 0, 1'b0, 1'b0);
    applyStimulus(randErr(), 1, 1, 1'b0, 1'b0);

    // Assert reset in the middle of a write-back. The lock must drop immediately.
    applyStimulus(16'h0100, 0, 3, 1'b0, 1'b1);
    tick(); rst_ni = 1'b1;
    applyStimulus('0, 0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
